// File: rtl/data_ram_wait_if.sv
`default_nettype none
// ============================================================================
// data_ram_wait_if : CPU data-memory port bundle (request, response, status)
// Revision 1.0
// ============================================================================
interface data_ram_wait_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        data_ready;
  logic        busy;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, data_ready, busy
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, data_ready, busy
  );
endinterface
`default_nettype wire

// File: rtl/data_ram_wait.sv
`default_nettype none
// ============================================================================
// data_ram_wait : data RAM responder inserting WAIT_CYCLES wait states per access
// Revision 1.0
// ============================================================================
module data_ram_wait #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  data_ram_wait_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_we_q;
  logic [ADDR_W-1:0]   req_idx_q;
  logic [3:0]          req_sel_q;
  logic [31:0]         req_data_q;
  logic [31:0]         data_o_q;
  logic [31:0]         mem_q [2**ADDR_W];

  logic                w_accept;
  logic                w_acc_fire;
  logic                w_acc_we;
  logic [ADDR_W-1:0]   w_acc_idx;
  logic [3:0]          w_acc_sel;
  logic [31:0]         w_acc_data;
  logic                unused_bits;

  assign w_accept = (state_q == S_IDLE) && bus.ce;

  // With no wait states the access happens on the accept edge, so it must
  // come straight from the bus rather than from the request registers.
  if (WAIT_CYCLES == 0) begin : g_zero_wait
    assign w_acc_fire = w_accept && rst;
    assign w_acc_we   = bus.we;
    assign w_acc_idx  = bus.addr[ADDR_W+1:2];
    assign w_acc_sel  = bus.sel;
    assign w_acc_data = bus.data_i;
  end else begin : g_wait
    assign w_acc_fire = (state_q == S_WAIT) && (cnt_q == 4'd1) && rst;
    assign w_acc_we   = req_we_q;
    assign w_acc_idx  = req_idx_q;
    assign w_acc_sel  = req_sel_q;
    assign w_acc_data = req_data_q;
  end

  assign unused_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0],
                         req_we_q, req_idx_q, req_sel_q, req_data_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.ce) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      req_we_q   <= 1'b0;
      req_idx_q  <= '0;
      req_sel_q  <= 4'd0;
      req_data_q <= 32'd0;
      data_o_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        req_we_q   <= bus.we;
        req_idx_q  <= bus.addr[ADDR_W+1:2];
        req_sel_q  <= bus.sel;
        req_data_q <= bus.data_i;
      end
      if (w_acc_fire && !w_acc_we) begin
        data_o_q <= mem_q[w_acc_idx];
      end
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst.
  always_ff @(posedge clk) begin
    if (w_acc_fire && w_acc_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_sel[i]) begin
          mem_q[w_acc_idx][8*i +: 8] <= w_acc_data[8*i +: 8];
        end
      end
    end
  end

  assign bus.data_o     = data_o_q;
  assign bus.data_ready = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_ram_wait.sv
`default_nettype none
// ============================================================================
// tb_data_ram_wait : directed bench for a 2-wait and a 0-wait responder
// Revision 1.0
// ============================================================================
module tb_data_ram_wait;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  data_ram_wait_if bus2 ();
  data_ram_wait_if bus0 ();

  data_ram_wait #(.ADDR_W(10), .WAIT_CYCLES(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  data_ram_wait #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request on the 2-wait port; inputs are scrambled right after acceptance
  task automatic req2(input string tag, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    bus2.ce = 1'b1; bus2.we = w; bus2.addr = a; bus2.sel = s; bus2.data_i = d;
    tick();
    bus2.ce = 1'b0; bus2.we = ~w; bus2.addr = a ^ 32'h10; bus2.sel = ~s; bus2.data_i = ~d;
    chk1({tag, "_busy_acc"}, bus2.busy, 1'b1);
    chk1({tag, "_rdy_k1"}, bus2.data_ready, 1'b0);
    tick();
    chk1({tag, "_rdy_k2"}, bus2.data_ready, 1'b0);
    tick();
    chk1({tag, "_rdy_k3"}, bus2.data_ready, 1'b1);
    chk1({tag, "_busy_k3"}, bus2.busy, 1'b1);
    tick();
    chk1({tag, "_rdy_k4"}, bus2.data_ready, 1'b0);
    chk1({tag, "_busy_k4"}, bus2.busy, 1'b0);
  endtask

  task automatic req0(input string tag, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
    bus0.ce = 1'b1; bus0.we = w; bus0.addr = a; bus0.sel = s; bus0.data_i = d;
    tick();
    bus0.ce = 1'b0; bus0.addr = 32'h0; bus0.data_i = 32'h0;
    chk1({tag, "_rdy_k1"}, bus0.data_ready, 1'b1);
    chk1({tag, "_busy_k1"}, bus0.busy, 1'b1);
    tick();
    chk1({tag, "_rdy_k2"}, bus0.data_ready, 1'b0);
    chk1({tag, "_busy_k2"}, bus0.busy, 1'b0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus2.ce = 1'b0; bus2.we = 1'b0; bus2.addr = 32'h0; bus2.sel = 4'h0; bus2.data_i = 32'h0;
    bus0.ce = 1'b0; bus0.we = 1'b0; bus0.addr = 32'h0; bus0.sel = 4'h0; bus0.data_i = 32'h0;
    repeat (3) tick();

    chk32("rst_data_o", bus2.data_o, 32'h0);
    chk1("rst_ready", bus2.data_ready, 1'b0);
    chk1("rst_busy", bus2.busy, 1'b0);
    chk32("rst0_data_o", bus0.data_o, 32'h0);
    rst = 1'b1;
    tick();

    // Store then load
    req2("st_dead", 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
    chk32("st_keeps_data_o", bus2.data_o, 32'h0);
    req2("ld_dead", 1'b0, 32'h10, 4'b0000, 32'h0);
    chk32("ld_dead_val", bus2.data_o, 32'hDEADBEEF);

    // Byte-lane store into word 4
    req2("pre_w4", 1'b1, 32'h10, 4'b1111, 32'h11223344);
    req2("lane2", 1'b1, 32'h12, 4'b0100, 32'hAABBCCDD);
    chk32("data_o_hold", bus2.data_o, 32'hDEADBEEF);
    req2("nop_st", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
    req2("ld_lane", 1'b0, 32'h10, 4'b1000, 32'h0);
    chk32("lane_val", bus2.data_o, 32'h11BB3344);

    // Hold-off: req2 perturbs addr/data/sel/we and drops ce during WAIT
    req2("hold_st", 1'b1, 32'h30, 4'b1111, 32'h55AA55AA);
    req2("hold_ld30", 1'b0, 32'h30, 4'b0000, 32'h0);
    chk32("hold_val30", bus2.data_o, 32'h55AA55AA);
    req2("hold_ld10", 1'b0, 32'h10, 4'b0000, 32'h0);
    chk32("hold_val10", bus2.data_o, 32'h11BB3344);

    // Zero wait states with aliasing above bit 11
    req0("z_st", 1'b1, 32'h0000_1004, 4'b1111, 32'h12345678);
    req0("z_ld", 1'b0, 32'h0000_0004, 4'b0000, 32'h0);
    chk32("z_alias_val", bus0.data_o, 32'h12345678);

    // Reset during WAIT of a store
    req2("pre_20", 1'b1, 32'h20, 4'b1111, 32'hCAFEF00D);
    bus2.ce = 1'b1; bus2.we = 1'b1; bus2.addr = 32'h20; bus2.sel = 4'b1111; bus2.data_i = 32'h0;
    tick();
    bus2.ce = 1'b0;
    tick();
    chk1("mid_busy_pre", bus2.busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk1("async_rdy", bus2.data_ready, 1'b0);
    chk1("async_busy", bus2.busy, 1'b0);
    chk32("async_data_o", bus2.data_o, 32'h0);
    tick();
    chk1("rst_hold_rdy", bus2.data_ready, 1'b0);
    rst = 1'b1;
    tick();
    chk1("post_rst_rdy", bus2.data_ready, 1'b0);
    tick();
    chk1("post_rst_rdy2", bus2.data_ready, 1'b0);
    req2("ld_20", 1'b0, 32'h20, 4'b0000, 32'h0);
    chk32("ld_20_val", bus2.data_o, 32'hCAFEF00D);

    // Back-to-back loads with ce held high
    bus2.ce = 1'b1; bus2.we = 1'b0; bus2.addr = 32'h10; bus2.sel = 4'b0000;
    tick();
    bus2.addr = 32'h30;
    chk1("b2b_busy1", bus2.busy, 1'b1);
    tick();
    chk1("b2b_rdy_a1", bus2.data_ready, 1'b0);
    tick();
    chk1("b2b_rdy_a2", bus2.data_ready, 1'b1);
    chk32("b2b_val_a", bus2.data_o, 32'h11BB3344);
    tick();
    chk1("b2b_idle_rdy", bus2.data_ready, 1'b0);
    chk1("b2b_idle_busy", bus2.busy, 1'b0);
    tick();
    bus2.ce = 1'b0;
    chk1("b2b_acc2_busy", bus2.busy, 1'b1);
    chk1("b2b_acc2_rdy", bus2.data_ready, 1'b0);
    tick();
    chk1("b2b_rdy_b1", bus2.data_ready, 1'b0);
    tick();
    chk1("b2b_rdy_b2", bus2.data_ready, 1'b1);
    chk32("b2b_val_b", bus2.data_o, 32'h55AA55AA);
    tick();
    chk1("b2b_end_rdy", bus2.data_ready, 1'b0);
    chk1("b2b_end_busy", bus2.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
